// File: rtl/relay_buf_if.sv
//==============================================================================
// Module      : relay_buf_if
// Description : Handshake/data bundle between an upstream producer, the
//               relay_buf stage and its downstream consumer. The optional
//               overflow flag exists only when RELAY_BUF_OVERFLOW_EN is
//               defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface relay_buf_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic                     enable;
  logic                     in_valid;
  logic signed [WIDTH-1:0]  in;
  logic                     _delay;
  logic                     delay_;
  logic                     valid;
  logic signed [WIDTH-1:0]  out;
  logic [c_cnt_w-1:0]       count;
`ifdef RELAY_BUF_OVERFLOW_EN
  logic                     overflow;
`endif

`ifdef RELAY_BUF_OVERFLOW_EN
  // Stage side: consumes controls and data, drives status and output.
  modport slave (
    input  enable, in_valid, in, _delay,
    output delay_, valid, out, count, overflow
  );

  // Environment side: drives controls and data, observes the stage.
  modport master (
    output enable, in_valid, in, _delay,
    input  delay_, valid, out, count, overflow
  );
`else
  // Stage side: consumes controls and data, drives status and output.
  modport slave (
    input  enable, in_valid, in, _delay,
    output delay_, valid, out, count
  );

  // Environment side: drives controls and data, observes the stage.
  modport master (
    output enable, in_valid, in, _delay,
    input  delay_, valid, out, count
  );
`endif

endinterface

`default_nettype wire

// File: rtl/relay_buf.sv
//==============================================================================
// Module      : relay_buf
// Description : Registered pass-through stage with a DEPTH-entry FIFO skid
//               buffer. Downstream stalls (_delay) park incoming data in the
//               FIFO; upstream back-pressure (delay_) is raised one slot
//               early so a producer that reacts a cycle late loses nothing.
//               An empty buffer bypasses straight to the output register.
//               WIDTH stands in for the datapath NUM_SIZE.
//               Optional feature macro: RELAY_BUF_OVERFLOW_EN adds a sticky
//               overflow flag that records any push dropped while full.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module relay_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4     // legal range DEPTH >= 2, any integer
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active low
  relay_buf_if.slave    bus
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = $clog2(DEPTH);

  localparam logic [c_cnt_w-1:0] c_full       = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_high_water = c_cnt_w'(DEPTH - 1);
  localparam logic [c_ptr_w-1:0] c_last_ptr   = c_ptr_w'(DEPTH - 1);

  // Storage and state
  logic signed [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0]       r_wr_ptr;
  logic [c_ptr_w-1:0]       r_rd_ptr;
  logic [c_cnt_w-1:0]       r_count;
  logic signed [WIDTH-1:0]  r_out;
  logic                     r_valid;
  logic                     r_delay;

  // Per-cycle decisions
  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_bypass;
  logic [c_cnt_w-1:0]       w_next_count;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Decide push / pop / bypass for this cycle from enable, stall and occupancy.
  always_comb begin
    w_empty  = (r_count == '0);
    w_full   = (r_count == c_full);
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_bypass = 1'b0;
    if (bus.enable) begin
      if (!bus._delay) begin
        if (!w_empty) begin
          // Head leaves while a new item may enter; legal even when full.
          w_pop  = 1'b1;
          w_push = bus.in_valid;
        end else begin
          // Nothing queued ahead, so the input may skip the FIFO.
          w_bypass = bus.in_valid;
        end
      end else begin
        // Stalled: park the input if there is room, otherwise it is lost.
        w_push = bus.in_valid && !w_full;
      end
    end
  end

  // Occupancy after this edge; drives both count and the back-pressure flag.
  always_comb begin
    w_next_count = r_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + c_cnt_w'(1);
      2'b01:   w_next_count = r_count - c_cnt_w'(1);
      default: w_next_count = r_count;
    endcase
  end

  // FIFO storage write; contents need no reset because pointers gate reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in;
    end
  end

  // Pointer, occupancy and back-pressure bookkeeping; all hold while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_delay  <= 1'b0;
    end else if (bus.enable) begin
      if (w_push) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      r_count <= w_next_count;
      // Raised one slot early so a one-cycle-late upstream still fits.
      r_delay <= (w_next_count >= c_high_water);
    end
  end

  // Output register: load head or bypassed input, hold when stalled, clear when disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (!bus.enable) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_out   <= r_mem[r_rd_ptr];
      r_valid <= 1'b1;
    end else if (w_bypass) begin
      r_out   <= bus.in;
      r_valid <= 1'b1;
    end else if (!bus._delay) begin
      // Downstream took the last item and nothing replaces it; out keeps its value.
      r_valid <= 1'b0;
    end
  end

`ifdef RELAY_BUF_OVERFLOW_EN
  logic w_drop;
  logic r_overflow;

  assign w_drop = bus.enable && bus._delay && bus.in_valid && w_full;

  // Sticky record of any input lost to a full buffer; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.overflow = r_overflow;
`endif

  assign bus.delay_ = r_delay;
  assign bus.valid  = r_valid;
  assign bus.out    = r_out;
  assign bus.count  = r_count;

endmodule

`default_nettype wire

// File: doc/relay_buf.md
Name: relay_buf

Overview:
- Parametrised successor to the single-entry stall relay.
- Registered pass-through stage with a DEPTH-entry FIFO skid buffer, so downstream stalls (_delay) do not lose data and upstream back-pressure (delay_) is asserted with one slot of slack.
- Sits between pipeline stages in the numeric datapath, chained like the original relay (delay_ of one feeds _delay of the previous).

Parameters:
- WIDTH, NUM_SIZE (from def.svh): data width, signed.
- DEPTH, 4: skid FIFO entries; legal range DEPTH >= 2; power of two not required.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  stage enable; when low, stage idles (see Behaviour).
- in_valid  input  1  upstream data valid.
- in  input  WIDTH  signed upstream data.
- _delay  input  1  downstream stall request.
- delay_  output  1  stall request to upstream, registered.
- valid  output  1  out holds a valid item, registered.
- out  output  WIDTH  signed output data, registered.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy, registered.
- overflow  output  1  sticky drop flag (only with RELAY_BUF_OVERFLOW_EN).

Behaviour:
- Reset (reset==0, async): out=0, valid=0, delay_=0, count=0, read/write pointers=0, overflow=0. Deassertion is synchronous to clk. Reset mid-stream discards all buffered data.
- enable==0: out<=0 and valid<=0. FIFO contents, count, pointers and delay_ hold. No push, pop or bypass. in is ignored.
- enable==1, _delay==0 (downstream ready):
  - FIFO non-empty: out<=head, valid<=1, pop. If in_valid, push in the same cycle; push+pop is legal even when full, and count is unchanged.
  - FIFO empty, in_valid: bypass, out<=in, valid<=1, 1-cycle latency. Count stays 0.
  - FIFO empty, !in_valid: valid<=0, out holds its last value.
- enable==1, _delay==1 (stalled): out and valid hold. If in_valid and count<DEPTH, push. If in_valid and count==DEPTH, data is dropped, count holds, and overflow is set.
- Ordering: strict FIFO. Items leave in arrival order; bypass occurs only when the FIFO is empty.
- Pointers wrap from DEPTH-1 to 0 explicitly (non-power-of-two safe).
- delay_ is registered: delay_ <= (next_count >= DEPTH-1). This leaves one slot of slack for an upstream that reacts one cycle late. It deasserts the cycle after next_count drops below DEPTH-1.
- count reflects the post-edge occupancy and never exceeds DEPTH.
- Latency: 1 cycle through an empty buffer. Otherwise 1 + items ahead + stall cycles.

Optional Feature:
- Macro: RELAY_BUF_OVERFLOW_EN.
- Defined: overflow port present. It sets on any dropped push (in_valid, _delay==1, count==DEPTH, enable==1) and clears only on reset.
- Undefined: overflow port and its register are absent. Drops are silent; all other behaviour is identical.

Test Plan:
- Reset then enable=1, _delay=0, in_valid=1 with in=5,-3,7 on consecutive cycles -> out=5,-3,7 one cycle later each, valid=1, count=0, delay_=0.
- DEPTH=4: hold _delay=1 and push 10,11,12 -> count=3. delay_=1 from the edge where count hits 3, out/valid hold the prior item. Release _delay -> out=10,11,12 in order, then bypass resumes.
- Full (count=4) with _delay=0 and in_valid=1, in=99 -> head popped to out and 99 pushed in the same cycle, count stays 4, no overflow.
- Full with _delay=1 and in_valid=1, in=42 -> 42 dropped, count=4, overflow=1 (macro on) and stays 1 until reset.
- enable=0 for 3 cycles with count=2 -> out=0, valid=0, count=2 held. Re-enable with _delay=0 -> the two buffered items emerge in order.
- Assert reset asynchronously mid-burst with count=3 -> immediate out=0, valid=0, count=0, delay_=0 without a clock edge. Afterwards, the first accepted input bypasses to out.
